// File: rtl/ram_read_check.sv
// Port-B read checker: walks the whole RAM once per start and compares each word
// against the writer's incrementing pattern, reporting done/pass/error details.
module ram_read_check #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 16,
    parameter int RD_LAT    = 1,
    parameter int DATA_BASE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              r_en,
    output logic [ADDR_W-1:0] r_addr,
    input  logic [DATA_W-1:0] r_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] ADDR_TOP = '1;
    localparam logic [DATA_W-1:0] BASE_C   = DATA_W'(DATA_BASE);

    logic [1:0]              state_q, state_d;
    logic                    r_en_q, r_en_d;
    logic [ADDR_W-1:0]       r_addr_q, r_addr_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    pass_q, pass_d;
    logic [ADDR_W:0]         err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0]       fe_addr_q, fe_addr_d;
    logic [DATA_W-1:0]       fe_data_q, fe_data_d;

    // Stage i holds the read issued i+1 cycles ago; the last stage is due for compare.
    logic [RD_LAT-1:0]                 pv_q, pv_d;
    logic [RD_LAT-1:0][ADDR_W-1:0]     pa_q, pa_d;

    logic                    cmp_valid;
    logic [ADDR_W-1:0]       cmp_addr;
    logic [DATA_W-1:0]       exp_data;
    logic                    mismatch;

    assign cmp_valid = pv_q[RD_LAT-1];
    assign cmp_addr  = pa_q[RD_LAT-1];
    assign exp_data  = BASE_C + DATA_W'(cmp_addr);
    assign mismatch  = cmp_valid && (r_data != exp_data);

    always_comb begin
        state_d   = state_q;
        r_en_d    = r_en_q;
        r_addr_d  = r_addr_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        err_cnt_d = err_cnt_q;
        fe_addr_d = fe_addr_q;
        fe_data_d = fe_data_q;

        pv_d[0] = r_en_q;
        pa_d[0] = r_addr_q;
        for (int i = 1; i < RD_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            pa_d[i] = pa_q[i-1];
        end

        if (mismatch) begin
            err_cnt_d = err_cnt_q + (ADDR_W+1)'(1);
            if (err_cnt_q == '0) begin
                fe_addr_d = cmp_addr;
                fe_data_d = r_data;
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_READ;
                    r_en_d    = 1'b1;
                    r_addr_d  = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    err_cnt_d = '0;
                    fe_addr_d = '0;
                    fe_data_d = '0;
                end
            end
            S_READ: begin
                // Address saturates at the top so the ILA shows where the walk ended.
                if (r_addr_q == ADDR_TOP) begin
                    state_d = S_DRAIN;
                    r_en_d  = 1'b0;
                end else begin
                    r_addr_d = r_addr_q + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                if (cmp_valid && (cmp_addr == ADDR_TOP)) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_d == '0);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            r_en_q    <= 1'b0;
            r_addr_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_cnt_q <= '0;
            fe_addr_q <= '0;
            fe_data_q <= '0;
            pv_q      <= '0;
            pa_q      <= '0;
        end else begin
            state_q   <= state_d;
            r_en_q    <= r_en_d;
            r_addr_q  <= r_addr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_cnt_q <= err_cnt_d;
            fe_addr_q <= fe_addr_d;
            fe_data_q <= fe_data_d;
            pv_q      <= pv_d;
            pa_q      <= pa_d;
        end
    end

    assign r_en           = r_en_q;
    assign r_addr         = r_addr_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_addr = fe_addr_q;
    assign first_err_data = fe_data_q;

endmodule

// File: tb/tb_ram_read_check.sv
// Bench for ram_read_check: two instances (latency 1/base 1 and latency 2/base FFFF)
// driven from RAM models, results compared against a whole-array reference model.
module tb_ram_read_check;

    localparam int AW    = 9;
    localparam int DW    = 16;
    localparam int DEPTH = 512;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst_n;
    logic start_pulse;
    logic sel;

    logic          start1, r_en1, busy1, done1, pass1;
    logic [AW-1:0] r_addr1, fea1;
    logic [DW-1:0] r_data1, fed1;
    logic [AW:0]   err1;

    logic          start2, r_en2, busy2, done2, pass2;
    logic [AW-1:0] r_addr2, fea2;
    logic [DW-1:0] r_data2, fed2, rd2_a;
    logic [AW:0]   err2;

    assign start1 = start_pulse & ~sel;
    assign start2 = start_pulse & sel;

    ram_read_check #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .DATA_BASE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .r_en(r_en1), .r_addr(r_addr1),
        .r_data(r_data1), .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
        .first_err_addr(fea1), .first_err_data(fed1)
    );

    ram_read_check #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .DATA_BASE(16'hFFFF)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .r_en(r_en2), .r_addr(r_addr2),
        .r_data(r_data2), .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
        .first_err_addr(fea2), .first_err_data(fed2)
    );

    // RAM models; idle cycles return junk that the checker must ignore.
    logic [DW-1:0] mem1 [DEPTH];
    logic [DW-1:0] mem2 [DEPTH];

    always @(posedge clk) r_data1 <= r_en1 ? mem1[r_addr1] : DW'($urandom);
    always @(posedge clk) begin
        rd2_a   <= r_en2 ? mem2[r_addr2] : DW'($urandom);
        r_data2 <= rd2_a;
    end

    logic          r_en_s, busy_s, done_s, pass_s;
    logic [AW-1:0] r_addr_s, fea_s;
    logic [DW-1:0] fed_s;
    logic [AW:0]   err_s;

    always_comb begin
        r_en_s   = sel ? r_en2   : r_en1;
        r_addr_s = sel ? r_addr2 : r_addr1;
        busy_s   = sel ? busy2   : busy1;
        done_s   = sel ? done2   : done1;
        pass_s   = sel ? pass2   : pass1;
        err_s    = sel ? err2    : err1;
        fea_s    = sel ? fea2    : fea1;
        fed_s    = sel ? fed2    : fed1;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int base_of(input logic s);
        return s ? 32'hFFFF : 32'h1;
    endfunction

    // Reference: count every word that differs from (base + a) mod 2^16.
    task automatic model(input logic s, output int errs, output int fa, output int fd);
        int w;
        errs = 0; fa = 0; fd = 0;
        for (int a = 0; a < DEPTH; a++) begin
            w = s ? int'(mem2[a]) : int'(mem1[a]);
            if (w != ((base_of(s) + a) % 65536)) begin
                if (errs == 0) begin
                    fa = a;
                    fd = w;
                end
                errs++;
            end
        end
    endtask

    task automatic fill(input logic s, input int all_ones);
        logic [DW-1:0] v;
        for (int a = 0; a < DEPTH; a++) begin
            v = all_ones ? 16'hFFFF : DW'((base_of(s) + a) % 65536);
            if (s) mem2[a] = v;
            else   mem1[a] = v;
        end
    endtask

    task automatic corrupt1(input int a);
        mem1[a] = DW'((1 + a) % 65536) ^ DW'($urandom_range(1, 65535));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_r_en"}, 32'(r_en_s), 0);
        check({tag, "_outs"}, {r_addr_s, busy_s, done_s, pass_s, err_s}, 0);
        check({tag, "_first"}, {fea_s, fed_s}, 0);
    endtask

    task automatic run_pass(input string tag, input int extra_start_at, input int abort_at);
        int cycles, en_cycles, addr_bad, exp_addr, lat;
        int errs, fa, fd;
        bit got_done;
        lat = sel ? 2 : 1;
        model(sel, errs, fa, fd);
        @(negedge clk);
        start_pulse = 1'b1;
        @(posedge clk);
        #1;
        start_pulse = 1'b0;
        check({tag, "_busy_start"}, {busy_s, done_s, pass_s}, 3'b100);
        cycles = 0; en_cycles = 0; addr_bad = 0; exp_addr = 0; got_done = 0;
        if (r_en_s) begin
            en_cycles++;
            if (int'(r_addr_s) != exp_addr) addr_bad++;
            exp_addr++;
        end
        while (cycles < 2000) begin
            @(posedge clk);
            cycles++;
            #1;
            start_pulse = (cycles == extra_start_at);
            if (cycles == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_zero({tag, "_abort"});
                repeat (2) @(posedge clk);
                #1;
                check_zero({tag, "_in_reset"});
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (r_en_s) begin
                en_cycles++;
                if (int'(r_addr_s) != exp_addr) addr_bad++;
                exp_addr++;
            end
            if (done_s) begin
                got_done = 1;
                break;
            end
        end
        start_pulse = 1'b0;
        check({tag, "_done_seen"}, 32'(got_done), 1);
        check({tag, "_latency"}, cycles, 512 + lat);
        check({tag, "_r_en_cycles"}, en_cycles, DEPTH);
        check({tag, "_addr_seq_bad"}, addr_bad, 0);
        check({tag, "_r_addr_last"}, 32'(r_addr_s), DEPTH - 1);
        check({tag, "_err_cnt"}, 32'(err_s), errs);
        check({tag, "_pass"}, 32'(pass_s), (errs == 0) ? 1 : 0);
        check({tag, "_busy_end"}, 32'(busy_s), 0);
        check({tag, "_first_addr"}, 32'(fea_s), fa);
        check({tag, "_first_data"}, 32'(fed_s), fd);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_hold"}, {done_s, busy_s, r_en_s, err_s}, {3'b100, AW'(0), 1'b0} | 32'(errs));
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        start_pulse = 1'b0;
        sel = 1'b0;
        fill(0, 0);
        fill(1, 0);
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset1");
        sel = 1'b1;
        #1;
        check_zero("reset2");
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        run_pass("clean", 0, 0);

        mem1[37] = 16'h0000;
        run_pass("addr37", 0, 0);

        fill(0, 0);
        corrupt1(5);
        corrupt1(300);
        corrupt1(511);
        run_pass("three", 0, 0);

        fill(0, 1);
        run_pass("all_ff", 0, 0);

        for (int k = 0; k < 2; k++) begin
            fill(0, 0);
            n = $urandom_range(1, 20);
            for (int j = 0; j < n; j++) mem1[$urandom_range(0, DEPTH - 1)] = DW'($urandom);
            run_pass("random", 0, 0);
        end

        fill(0, 0);
        run_pass("extra_start", 100, 0);

        mem1[10] = 16'h1234;
        run_pass("abort", 0, 200);
        mem1[10] = 16'd11;
        run_pass("after_abort", 0, 0);

        sel = 1'b1;
        run_pass("lat2_wrap", 0, 0);
        mem2[1] = 16'h5A5A;
        corrupt1(0);
        run_pass("lat2_err", 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
